// File: rtl/tlc_light_monitor.sv
// rtl/tlc_light_monitor.sv - lamp-output safety watchdog for the traffic light controller
// Decodes lamps into a phase each cycle, checks sequence and dwell bounds, counts green cycles.
module tlc_light_monitor #(
    parameter int MIN_GREEN  = 2,
    parameter int MIN_YELLOW = 1,
    parameter int MAX_YELLOW = 2,
    parameter int CNT_W      = 8
) (
    input  logic             CLK,
    input  logic             clr,
    input  logic             MG,
    input  logic             MY,
    input  logic             MR,
    input  logic             MA,
    input  logic             SG,
    input  logic             SY,
    input  logic             SR,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] dwell,
    output logic             err_conflict,
    output logic             err_lamp,
    output logic             err_seq,
    output logic             err_time,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] main_cycles,
    output logic [CNT_W-1:0] side_cycles
);

    typedef enum logic [2:0] {
        P_INIT = 3'd0,
        P_MG   = 3'd1,
        P_MY   = 3'd2,
        P_AR   = 3'd3,
        P_SG   = 3'd4,
        P_SY   = 3'd5,
        P_BAD  = 3'd7
    } phase_t;

    localparam logic [CNT_W-1:0] DWELL_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_G     = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_Y     = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MAX_Y     = CNT_W'(MAX_YELLOW);

    phase_t     cur;
    phase_t     nxt;
    logic       last_side;
    logic       main_ok;
    logic       side_ok;
    logic       conflict;
    logic       lamp_bad;
    logic       trans;
    logic       seq_ok;
    logic       seq_bad;
    logic       time_bad;
    logic [2:0] code_now;

    assign phase = cur;

    always_comb begin
        main_ok  = (MG & ~MY & ~MR) | (~MG & MY & ~MR) | (~MG & ~MY & MR);
        side_ok  = (SG & ~SY & ~SR) | (~SG & SY & ~SR) | (~SG & ~SY & SR);
        conflict = (MG | MY) & (SG | SY);
        lamp_bad = ~main_ok | ~side_ok | (MA & ~MG);

        // Only meaningful when both roads are one-hot and not in conflict.
        nxt = P_AR;
        if (MG)
            nxt = P_MG;
        else if (MY)
            nxt = P_MY;
        else if (SG)
            nxt = P_SG;
        else if (SY)
            nxt = P_SY;

        trans = ~conflict & ~lamp_bad & (cur != P_INIT) & (cur != P_BAD) & (nxt != cur);

        seq_ok = 1'b0;
        case (cur)
            P_MG:    seq_ok = (nxt == P_MY);
            P_SG:    seq_ok = (nxt == P_SY);
            P_MY:    seq_ok = (nxt == P_SG) | (nxt == P_AR);
            P_SY:    seq_ok = (nxt == P_MG) | (nxt == P_AR);
            P_AR:    seq_ok = last_side ? (nxt == P_MG) : (nxt == P_SG);
            default: seq_ok = 1'b0;
        endcase
        seq_bad = trans & ~seq_ok;

        time_bad = 1'b0;
        if (trans) begin
            if ((cur == P_MG || cur == P_SG) && dwell < MIN_G)
                time_bad = 1'b1;
            if ((cur == P_MY || cur == P_SY) && (dwell < MIN_Y || dwell > MAX_Y))
                time_bad = 1'b1;
        end

        code_now = 3'd0;
        if (conflict)
            code_now = 3'd1;
        else if (lamp_bad)
            code_now = 3'd2;
        else if (seq_bad)
            code_now = 3'd3;
        else if (time_bad)
            code_now = 3'd4;
    end

    always_ff @(posedge CLK) begin
        if (!clr) begin
            cur          <= P_INIT;
            dwell        <= '0;
            err_conflict <= 1'b0;
            err_lamp     <= 1'b0;
            err_seq      <= 1'b0;
            err_time     <= 1'b0;
            err_code     <= 3'd0;
            main_cycles  <= '0;
            side_cycles  <= '0;
            last_side    <= 1'b1;
        end else begin
            if (conflict) err_conflict <= 1'b1;
            if (lamp_bad) err_lamp     <= 1'b1;
            if (seq_bad)  err_seq      <= 1'b1;
            if (time_bad) err_time     <= 1'b1;
            if (err_code == 3'd0)
                err_code <= code_now;

            if (conflict || lamp_bad) begin
                cur   <= P_BAD;
                dwell <= CNT_W'(1);
            end else if (nxt == cur) begin
                if (dwell != DWELL_MAX)
                    dwell <= dwell + 1'b1;
            end else begin
                cur   <= nxt;
                dwell <= CNT_W'(1);
                if (nxt == P_MY) last_side <= 1'b0;
                if (nxt == P_SY) last_side <= 1'b1;
                if (trans && cur == P_MG && nxt == P_MY && main_cycles != DWELL_MAX)
                    main_cycles <= main_cycles + 1'b1;
                if (trans && cur == P_SG && nxt == P_SY && side_cycles != DWELL_MAX)
                    side_cycles <= side_cycles + 1'b1;
            end
        end
    end

endmodule

// File: doc/tlc_light_monitor.md
Name: tlc_light_monitor

Overview:
- Passive checker/observer on the lamp outputs of the traffic light controller (MG, MY, MR, MA, SR, SY, SG). It is the reader of the controller's light interface.
- Each clock it decodes the lamps into an intersection phase and tracks phase dwell time.
- It flags unsafe or illegal lamp combinations, illegal phase sequences and yellow/green timing violations.
- It counts completed green cycles per road. It sits beside the controller in benches and on-chip as a safety watchdog.

Parameters:
- MIN_GREEN, 2, minimum cycles a green phase (P_MG or P_SG) must dwell before leaving.
- MIN_YELLOW, 1, minimum cycles in a yellow phase (P_MY or P_SY).
- MAX_YELLOW, 2, maximum cycles in a yellow phase.
- CNT_W, 8, width of the dwell counter and the green-cycle counters.

Ports:
- CLK  input  1  rising-edge clock, shared with the controller.
- clr  input  1  synchronous, active-low reset (clr=0 at a rising CLK edge resets the block).
- MG, MY, MR  input  1 each  main-road green/yellow/red lamps.
- MA  input  1  main-road arrow lamp.
- SG, SY, SR  input  1 each  side-road green/yellow/red lamps.
- phase  output  3  current decoded phase: 0 INIT, 1 P_MG, 2 P_MY, 3 P_AR, 4 P_SG, 5 P_SY, 7 P_BAD.
- dwell  output  CNT_W  cycles spent in the current phase, counting the entry cycle.
- err_conflict  output  1  sticky; both roads non-red in the same cycle.
- err_lamp  output  1  sticky; a road not exactly one-hot, or MA=1 without MG=1.
- err_seq  output  1  sticky; illegal phase transition.
- err_time  output  1  sticky; dwell bound violated.
- err_code  output  3  code of the first error since reset: 0 none, 1 conflict, 2 lamp, 3 seq, 4 time.
- main_cycles, side_cycles  output  CNT_W each  completed P_MG->P_MY and P_SG->P_SY transitions, saturating.

Behaviour:
- Timing: all outputs are registered and update on the rising CLK edge that samples the inputs. Latency is one edge.
- Reset (clr=0 at an edge): phase=0, dwell=0, all err_* =0, err_code=0, both counters=0. Reset mid-operation discards all history. The first sample after reset is treated as from INIT.
- Decode (combinational, on sampled inputs):
  - Main legal iff exactly one of MG/MY/MR. Side legal iff exactly one of SG/SY/SR.
  - P_MG = MG&SR; P_MY = MY&SR; P_SG = MR&SG; P_SY = MR&SY; P_AR = MR&SR.
  - Conflict = (MG|MY)&(SG|SY).
  - Lamp error = either road not one-hot, or MA&~MG.
- Priority when several errors are detected in the same sample: conflict > lamp > seq > time.
  - Every detected error sets its own sticky flag.
  - err_code loads only while it is 0, using the highest-priority code detected that cycle.
- Conflict or lamp error in a sample: phase<=P_BAD, dwell<=1. No seq or time check is made that cycle.
- From INIT or P_BAD, the next legal phase is accepted with no seq or time check. dwell<=1.
- Same decoded phase as the previous sample: dwell increments and saturates at 2^CNT_W-1. No checks.
- Legal transitions:
  - P_MG->P_MY, P_SG->P_SY.
  - P_MY->P_SG or P_AR. P_SY->P_MG or P_AR.
  - P_AR->P_SG if the last yellow was P_MY. P_AR->P_MG if the last yellow was P_SY.
  - A one-bit last_yellow register records this. It resets to "side", so the first P_AR->P_MG is legal.
- Any other phase change sets err_seq. The new phase is still adopted and dwell<=1.
- Timing checks use the dwell of the phase being left:
  - Leaving P_MG or P_SG with dwell<MIN_GREEN sets err_time.
  - Leaving P_MY or P_SY with dwell<MIN_YELLOW or dwell>MAX_YELLOW sets err_time.
  - The check applies even if the transition is also a seq error; both flags set, and err_code follows priority.
- Counters: main_cycles increments on each P_MG->P_MY, side_cycles on each P_SG->P_SY. Both saturate at all-ones and never wrap.
- Steady P_AR is legal indefinitely and has no timing bound.

Test Plan:
- Reset, then MG=SR=1 for 3 cycles, MY=SR=1 for 1, MR=SG=1 for 3, MR=SY=1 for 1, MG=SR=1 -> phase 1,2,4,5,1; main_cycles=1, side_cycles=1; all err_*=0; err_code=0.
- From P_MG (dwell 3), drive MG=SG=1 for one cycle -> err_conflict=1, phase=7, err_code=1. Then MG=SR=1 -> phase=1, no err_seq.
- P_MG for 1 cycle then P_MY (MIN_GREEN=2) -> err_time=1, err_code=4, main_cycles=1.
- P_MY held 3 cycles (MAX_YELLOW=2) then P_SG -> err_time=1 on the transition edge. Dwell in P_MY reads 1,2,3.
- P_MG directly to P_SG -> err_seq=1, err_code=3, phase=4. Then MA=1 with MR=1 -> err_lamp=1, err_code stays 3.
- Mid-sequence, clr=0 for one edge -> all outputs 0 the next cycle. The next sample MR=SY=1 is accepted as P_SY with no errors.
